// File: rtl/simplecore_pkg.sv
// rtl/simplecore_pkg.sv - shared encodings for the SimpleCore data-bus arbiter
package simplecore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dbus_state_t;

    localparam logic GNT_C = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage

// File: rtl/dbus_arb_pick.sv
// rtl/dbus_arb_pick.sv - winner select; DBUS_ARB_RR_EN selects round-robin, else fixed core priority
module dbus_arb_pick
    import simplecore_pkg::*;
(
    input  logic cReq,
    input  logic dReq,
    input  logic last,
    output logic grant
);

`ifdef DBUS_ARB_RR_EN
    // On contention, the port that did not win last time goes next.
    always_comb begin
        grant = GNT_C;
        if (cReq && dReq)
            grant = (last == GNT_C) ? GNT_D : GNT_C;
        else if (dReq)
            grant = GNT_D;
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant = GNT_C;
        if (!cReq && dReq)
            grant = GNT_D;
    end
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-port data-memory bus arbiter with fixed wait states (DBUS_ARB_RR_EN: round-robin)
module dbus_arbiter
    import simplecore_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cReq,
    input  logic [AW-1:0] cAddr,
    input  logic [DW-1:0] cWData,
    input  logic          cnRW,
    output logic [DW-1:0] cRData,
    output logic          cAck,
    output logic          cWait,
    input  logic          dReq,
    input  logic [AW-1:0] dAddr,
    input  logic [DW-1:0] dWData,
    input  logic          dnRW,
    output logic [DW-1:0] dRData,
    output logic          dAck,
    output logic          mEn,
    output logic [AW-1:0] mAddr,
    output logic [DW-1:0] mWData,
    output logic          mnRW,
    input  logic [DW-1:0] mRData
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    dbus_state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic        grant_q;
    logic        last_q;
    logic        pick;

    dbus_arb_pick u_pick (
        .cReq  (cReq),
        .dReq  (dReq),
        .last  (last_q),
        .grant (pick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cReq || dReq) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            grant_q <= GNT_C;
            last_q  <= GNT_D;
            mAddr   <= '0;
            mWData  <= '0;
            mnRW    <= RD;
            cRData  <= '0;
            dRData  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    // Requester inputs are captured only here; later changes are ignored.
                    if (cReq || dReq) begin
                        grant_q <= pick;
                        cnt_q   <= WAIT_CNT;
                        mAddr   <= (pick == GNT_D) ? dAddr  : cAddr;
                        mWData  <= (pick == GNT_D) ? dWData : cWData;
                        mnRW    <= (pick == GNT_D) ? dnRW   : cnRW;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (mnRW == RD) begin
                            if (grant_q == GNT_D) dRData <= mRData;
                            else                  cRData <= mRData;
                        end
                        mnRW <= RD;
                    end
                end
                ST_DONE: last_q <= grant_q;
                default: ;
            endcase
        end
    end

    assign mEn   = (state_q == ST_ACCESS);
    assign cAck  = (state_q == ST_DONE) && (grant_q == GNT_C);
    assign dAck  = (state_q == ST_DONE) && (grant_q == GNT_D);
    assign cWait = cReq & ~cAck;

endmodule
